alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter SEL_W, default 5: ALU select width; legal values are 5 and above; the codes below are zero-extended.
REQ-002 SHALL have parameter MULT_CYCLES, default 4: mult execution cycles; legal values are 2 to 255.
REQ-003 SHALL have parameter DIV_CYCLES, default 8: div execution cycles; legal values are 2 to 255; used only under ALU_DIV_EN.
REQ-004 SHALL have ports: clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have ports: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports: Funct  input  6  R-type function field.
REQ-007 SHALL have ports: ALUOp  input  2  main-decoder ALU class.
REQ-008 SHALL have ports: op_valid  input  1  Funct and ALUOp are valid this cycle.
REQ-009 SHALL have ports: op_ready  output  1  the block can accept an op this cycle.
REQ-010 SHALL have ports: ALUsel  output  SEL_W  registered ALU select.
REQ-011 SHALL have ports: sel_valid  output  1  one-cycle pulse: ALUsel holds a newly completed op.
REQ-012 SHALL have ports: stall  output  1  a multi-cycle op is in progress; the pipeline holds PC and IR.
REQ-013 SHALL have ports: illegal  output  1  one-cycle pulse: the accepted op decoded to an undefined Funct.

Function
REQ-014 SHALL accept an op on a rising edge where op_valid=1 and op_ready=1; op_ready SHALL equal the state being IDLE.
REQ-015 SHALL decode an accepted op as follows:
- ALUOp 00: add, 00000
- ALUOp 01: sub, 00001
- ALUOp 11: slt, 11100
- ALUOp 10 with Funct 100000: add, 00000
- ALUOp 10 with Funct 100010: sub, 00001
- ALUOp 10 with Funct 100100: and, 10010
- ALUOp 10 with Funct 100101: or, 10011
- ALUOp 10 with Funct 011000: mult, 00111
- ALUOp 10 with Funct 000000: sll, 11000
- ALUOp 10 with Funct 000010: srl, 11001
- ALUOp 10 with Funct 101010: slt, 11100
- any other Funct under ALUOp 10: 11111
REQ-016 SHALL have exactly one decode per Funct value; no Funct value SHALL map to two codes.
REQ-017 SHALL use the FSM states IDLE and BUSY.
REQ-018 SHALL treat single-cycle ops as follows: when one is accepted at edge k, ALUsel is updated and sel_valid=1 after edge k, and the state stays IDLE, so back-to-back ops are accepted every cycle.
REQ-019 SHALL treat mult as follows:
- At acceptance, ALUsel=00111 immediately, the state goes to BUSY, and a cycle counter loads MULT_CYCLES-1.
- stall=1 and op_ready=0 while in BUSY.
REQ-020 SHALL decrement the counter by 1 per cycle in BUSY; when the counter is 0, the next edge SHALL return to IDLE with sel_valid=1, stall=0, and ALUsel unchanged.
REQ-021 SHALL complete a mult so that sel_valid pulses exactly MULT_CYCLES cycles after acceptance, and stall is high for MULT_CYCLES cycles.
REQ-022 SHALL hold ALUsel at its last value when no op is accepted; op_valid in BUSY SHALL be ignored, with no queuing.
REQ-023 SHALL pulse illegal=1 together with sel_valid for an undefined Funct, with ALUsel=11111, and no stall.
REQ-024 SHALL ignore Funct and ALUOp when op_valid=0.
REQ-025 SHALL drive the counter only in BUSY; an 8-bit counter is sufficient for all legal parameter values.

Reset
REQ-026 SHALL force, on rst_n=0 and asynchronously: state=IDLE, counter=0, ALUsel=0 (add), sel_valid=0, illegal=0, stall=0.
REQ-027 SHALL give op_ready=1 from the first edge after rst_n deasserts.
REQ-028 SHALL abort a mult in progress on reset mid-op with no sel_valid pulse for the aborted op.

Configuration
REQ-029 SHALL, with macro ALU_DIV_EN defined, decode Funct 011010 under ALUOp 10 to div, 01000, as a multi-cycle op with DIV_CYCLES latency using the same BUSY/counter mechanism.
REQ-030 SHALL, with ALU_DIV_EN undefined, treat Funct 011010 as undefined, giving 11111 and an illegal pulse; the DIV_CYCLES parameter SHALL have no effect.

Verification
REQ-031 SHALL cover reset: rst_n low mid-cycle -> ALUsel=00000, stall=0, op_ready=0 while low, op_ready=1 after release.
REQ-032 SHALL cover back-to-back ops: ALUOp=10 with Funct 100100, then 100101, then 000010 on consecutive cycles -> ALUsel 10010, 10011, 11001 on consecutive cycles, each with sel_valid=1.
REQ-033 SHALL cover mult with MULT_CYCLES=4: Funct 011000 -> stall high 4 cycles, op_ready low 4 cycles, sel_valid exactly 4 cycles after acceptance, ALUsel=00111; an op_valid presented during BUSY is ignored.
REQ-034 SHALL cover an illegal op: ALUOp=10 with Funct 111111 -> ALUsel=11111, illegal and sel_valid pulse 1 cycle, stall=0.
REQ-035 SHALL cover reset mid-mult: rst_n low 2 cycles into a mult -> no sel_valid, state IDLE, stall=0 immediately.
REQ-036 SHALL cover div: Funct 011010 -> with ALU_DIV_EN and DIV_CYCLES=8, ALUsel=01000 and stall 8 cycles; without the macro, ALUsel=11111, illegal=1, and no stall.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes Funct/ALUOp into a registered ALU select and
// sequences multi-cycle ops (mult, optional div) with a stall.
// Optional feature macro: ALU_DIV_EN (adds multi-cycle div, Funct 011010).
module alu_ctrl_seq #(
   parameter int SEL_W       = 5,
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       Funct,
   input  logic [1:0]       ALUOp,
   input  logic             op_valid,
   output logic             op_ready,
   output logic [SEL_W-1:0] ALUsel,
   output logic             sel_valid,
   output logic             stall,
   output logic             illegal
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [4:0] SEL_ADD  = 5'b00000;
   localparam logic [4:0] SEL_SUB  = 5'b00001;
   localparam logic [4:0] SEL_AND  = 5'b10010;
   localparam logic [4:0] SEL_OR   = 5'b10011;
   localparam logic [4:0] SEL_MULT = 5'b00111;
   localparam logic [4:0] SEL_SLL  = 5'b11000;
   localparam logic [4:0] SEL_SRL  = 5'b11001;
   localparam logic [4:0] SEL_SLT  = 5'b11100;
   localparam logic [4:0] SEL_ILL  = 5'b11111;
`ifdef ALU_DIV_EN
   localparam logic [4:0] SEL_DIV  = 5'b01000;
`endif

   // Elaboration-time guard on parameter ranges (8-bit counter, 5-bit codes).
   if (SEL_W < 5) begin : g_bad_sel_w
      $error("alu_ctrl_seq: SEL_W must be >= 5");
   end
   if (MULT_CYCLES < 2 || MULT_CYCLES > 255) begin : g_bad_mult
      $error("alu_ctrl_seq: MULT_CYCLES must be 2..255");
   end
   if (DIV_CYCLES < 2 || DIV_CYCLES > 255) begin : g_bad_div
      $error("alu_ctrl_seq: DIV_CYCLES must be 2..255");
   end

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [SEL_W-1:0] alusel_q, alusel_d;
   logic             sel_valid_q, sel_valid_d;
   logic             illegal_q, illegal_d;
   logic             rdy_q, rdy_d;

   logic [4:0]       dec_code;
   logic             dec_multi;
   logic             dec_illegal;
   logic [7:0]       dec_load;

   // Decode the presented op; multi-cycle ops also supply their counter preload.
   always_comb begin
      dec_code    = SEL_ADD;
      dec_multi   = 1'b0;
      dec_illegal = 1'b0;
      dec_load    = 8'd0;
      unique case (ALUOp)
         2'b00: dec_code = SEL_ADD;
         2'b01: dec_code = SEL_SUB;
         2'b11: dec_code = SEL_SLT;
         default: begin
            unique case (Funct)
               6'b100000: dec_code = SEL_ADD;
               6'b100010: dec_code = SEL_SUB;
               6'b100100: dec_code = SEL_AND;
               6'b100101: dec_code = SEL_OR;
               6'b011000: begin
                  dec_code  = SEL_MULT;
                  dec_multi = 1'b1;
                  dec_load  = 8'(MULT_CYCLES - 1);
               end
               6'b000000: dec_code = SEL_SLL;
               6'b000010: dec_code = SEL_SRL;
               6'b101010: dec_code = SEL_SLT;
`ifdef ALU_DIV_EN
               6'b011010: begin
                  dec_code  = SEL_DIV;
                  dec_multi = 1'b1;
                  dec_load  = 8'(DIV_CYCLES - 1);
               end
`endif
               default: begin
                  dec_code    = SEL_ILL;
                  dec_illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

   // Next-state logic: accept in IDLE, count down in BUSY, pulse on completion.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alusel_d    = alusel_q;
      sel_valid_d = 1'b0;
      illegal_d   = 1'b0;
      rdy_d       = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (op_valid && op_ready) begin
               alusel_d = SEL_W'(dec_code);
               if (dec_multi) begin
                  state_d = BUSY;
                  cnt_d   = dec_load;
               end else begin
                  sel_valid_d = 1'b1;
                  illegal_d   = dec_illegal;
               end
            end
         end
         default: begin
            // ALUsel already holds the multi-cycle code; only completion is signalled.
            if (cnt_q == 8'd0) begin
               state_d     = IDLE;
               sel_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
      endcase
   end

   // State and output registers; reset aborts any op in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         alusel_q    <= '0;
         sel_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alusel_q    <= alusel_d;
         sel_valid_q <= sel_valid_d;
         illegal_q   <= illegal_d;
         rdy_q       <= rdy_d;
      end
   end

   // rdy_q keeps op_ready low during reset and until the first edge after release.
   assign op_ready  = rdy_q && (state_q == IDLE);
   assign stall     = (state_q == BUSY);
   assign ALUsel    = alusel_q;
   assign sel_valid = sel_valid_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: a cycle-level reference model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_alu_ctrl_seq;
   localparam int SW = 5;
   localparam int MC = 4;
   localparam int DC = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [5:0]    Funct = '0;
   logic [1:0]    ALUOp = '0;
   logic          op_valid = 1'b0;
   logic          op_ready;
   logic [SW-1:0] ALUsel;
   logic          sel_valid;
   logic          stall;
   logic          illegal;

   int total = 0;
   int bad   = 0;
   bit done  = 1'b0;

   alu_ctrl_seq #(.SEL_W(SW), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .Funct(Funct), .ALUOp(ALUOp),
      .op_valid(op_valid), .op_ready(op_ready), .ALUsel(ALUsel),
      .sel_valid(sel_valid), .stall(stall), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Spec table lookup: returns code and the number of stall cycles (0 = single cycle).
   function automatic void lookup(input logic [1:0] aop, input logic [5:0] f,
                                  output logic [4:0] code, output int cyc);
      cyc = 0;
      if (aop == 2'b00)      code = 5'b00000;
      else if (aop == 2'b01) code = 5'b00001;
      else if (aop == 2'b11) code = 5'b11100;
      else begin
         case (f)
            6'b100000: code = 5'b00000;
            6'b100010: code = 5'b00001;
            6'b100100: code = 5'b10010;
            6'b100101: code = 5'b10011;
            6'b011000: begin code = 5'b00111; cyc = MC; end
            6'b000000: code = 5'b11000;
            6'b000010: code = 5'b11001;
            6'b101010: code = 5'b11100;
`ifdef ALU_DIV_EN
            6'b011010: begin code = 5'b01000; cyc = DC; end
`endif
            default:   code = 5'b11111;
         endcase
      end
   endfunction

   logic [4:0] m_sel;
   logic       m_sv, m_ill, m_started;
   int         m_left;   // stall cycles still to come

   always @(posedge clk or negedge rst_n) begin
      logic [4:0] c;
      int         n;
      if (!rst_n) begin
         m_sel = '0; m_sv = 0; m_ill = 0; m_left = 0; m_started = 0;
      end else begin
         m_sv = 0; m_ill = 0;
         if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_sv = 1;
         end else if (m_started && op_valid) begin
            lookup(ALUOp, Funct, c, n);
            m_sel = c;
            if (n > 0) m_left = n;
            else begin
               m_sv  = 1;
               m_ill = (c == 5'b11111);
            end
         end
         m_started = 1;
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      while (!done) begin
         @(posedge clk);
         #2;
         if (!done) begin
            chk("m_alusel",    32'(ALUsel),    32'(m_sel));
            chk("m_sel_valid", 32'(sel_valid), 32'(m_sv));
            chk("m_illegal",   32'(illegal),   32'(m_ill));
            chk("m_stall",     32'(stall),     32'(m_left > 0));
            chk("m_op_ready",  32'(op_ready),  32'(m_started && m_left == 0 && rst_n));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] f);
      op_valid = v; ALUOp = aop; Funct = f;
   endtask

   typedef struct { logic [1:0] aop; logic [5:0] f; logic [4:0] code; logic ill; } vec_t;
   vec_t vecs[10];

   initial begin
      int n;
      vecs[0] = '{2'b00, 6'b101010, 5'b00000, 1'b0};
      vecs[1] = '{2'b01, 6'b100000, 5'b00001, 1'b0};
      vecs[2] = '{2'b11, 6'b011000, 5'b11100, 1'b0};
      vecs[3] = '{2'b10, 6'b100000, 5'b00000, 1'b0};
      vecs[4] = '{2'b10, 6'b100010, 5'b00001, 1'b0};
      vecs[5] = '{2'b10, 6'b000000, 5'b11000, 1'b0};
      vecs[6] = '{2'b10, 6'b101010, 5'b11100, 1'b0};
      vecs[7] = '{2'b10, 6'b100001, 5'b11111, 1'b1};
      vecs[8] = '{2'b10, 6'b011001, 5'b11111, 1'b1};
      vecs[9] = '{2'b10, 6'b100101, 5'b10011, 1'b0};

      // Reset held: outputs at reset values, not ready.
      step(); step();
      #1;
      chk("rst_alusel", 32'(ALUsel), 32'h0);
      chk("rst_stall",  32'(stall),  32'h0);
      chk("rst_ready",  32'(op_ready), 32'h0);
      chk("rst_sv",     32'(sel_valid), 32'h0);
      rst_n = 1'b1;
      step();
      chk("rel_ready", 32'(op_ready), 32'h1);

      // Back-to-back and, or, srl.
      drive(1, 2'b10, 6'b100100); step();
      chk("b2b_and", 32'(ALUsel), 32'h12); chk("b2b_and_sv", 32'(sel_valid), 32'h1);
      drive(1, 2'b10, 6'b100101); step();
      chk("b2b_or",  32'(ALUsel), 32'h13); chk("b2b_or_sv",  32'(sel_valid), 32'h1);
      drive(1, 2'b10, 6'b000010); step();
      chk("b2b_srl", 32'(ALUsel), 32'h19); chk("b2b_srl_sv", 32'(sel_valid), 32'h1);

      // Idle with garbage inputs: nothing accepted, ALUsel held.
      drive(0, 2'b01, 6'b111111); step();
      chk("idle_sv",  32'(sel_valid), 32'h0);
      chk("idle_sel", 32'(ALUsel), 32'h19);

      // Table sweep.
      foreach (vecs[i]) begin
         drive(1, vecs[i].aop, vecs[i].f); step();
         chk("vec_sel", 32'(ALUsel),  32'(vecs[i].code));
         chk("vec_ill", 32'(illegal), 32'(vecs[i].ill));
      end
      drive(0, 2'b00, 6'b0); step();

      // Mult with an op held during BUSY that must be ignored.
      drive(1, 2'b10, 6'b011000); step();
      chk("mul_sel",   32'(ALUsel),   32'h07);
      chk("mul_stall", 32'(stall),    32'h1);
      chk("mul_ready", 32'(op_ready), 32'h0);
      chk("mul_sv0",   32'(sel_valid), 32'h0);
      drive(1, 2'b01, 6'b000000);
      n = 1;
      while (stall === 1'b1 && n < 40) begin
         step();
         if (stall === 1'b1) n++;
      end
      chk("mul_stall_cycles", 32'(n), 32'(MC));
      chk("mul_done_sv",  32'(sel_valid), 32'h1);
      chk("mul_done_sel", 32'(ALUsel), 32'h07);
      drive(0, 2'b00, 6'b0); step();
      chk("mul_noqueue_sv",  32'(sel_valid), 32'h0);
      chk("mul_noqueue_sel", 32'(ALUsel), 32'h07);

      // Illegal op.
      drive(1, 2'b10, 6'b111111); step();
      chk("ill_sel",   32'(ALUsel),   32'h1f);
      chk("ill_pulse", 32'(illegal),  32'h1);
      chk("ill_sv",    32'(sel_valid), 32'h1);
      chk("ill_stall", 32'(stall),    32'h0);
      drive(0, 2'b00, 6'b0); step();
      chk("ill_clear", 32'(illegal), 32'h0);

      // Div.
      drive(1, 2'b10, 6'b011010); step();
`ifdef ALU_DIV_EN
      drive(0, 2'b00, 6'b0);
      chk("div_sel", 32'(ALUsel), 32'h08);
      n = (stall === 1'b1) ? 1 : 0;
      while (stall === 1'b1 && n < 40) begin
         step();
         if (stall === 1'b1) n++;
      end
      chk("div_stall_cycles", 32'(n), 32'(DC));
      chk("div_done_sv", 32'(sel_valid), 32'h1);
`else
      chk("div_sel",   32'(ALUsel),  32'h1f);
      chk("div_ill",   32'(illegal), 32'h1);
      chk("div_stall", 32'(stall),   32'h0);
`endif
      drive(0, 2'b00, 6'b0); step();

      // Reset two cycles into a mult.
      drive(1, 2'b10, 6'b011000); step();
      drive(0, 2'b00, 6'b0); step(); step();
      rst_n = 1'b0;
      #1;
      chk("rmul_stall", 32'(stall),     32'h0);
      chk("rmul_sel",   32'(ALUsel),    32'h0);
      chk("rmul_sv",    32'(sel_valid), 32'h0);
      chk("rmul_ready", 32'(op_ready),  32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("rmul_ready_after", 32'(op_ready), 32'h1);
      for (int i = 0; i < MC + 2; i++) begin
         step();
         chk("rmul_no_sv", 32'(sel_valid), 32'h0);
      end

      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute runtime bound.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end
endmodule
